seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, 9, pattern length in bits (2..32).
REQ-002 Parameter PATTERN, 9'd472 (111011000), target pattern; PATTERN[PAT_W-1] is the first-arriving bit.
REQ-003 Parameter MASK, all ones, per-bit compare enable; a 0 bit is don't-care.
REQ-004 Parameter FRAME_LEN, 16, valid bits in a frame after a match (>=1).
REQ-005 Parameter RESYNC, 0; 0 = clear pattern window at frame end, 1 = keep it.
REQ-006 Parameter CNT_W, 16, match counter width.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 dataValid  in  1  dataIn is sampled only when high.
REQ-010 dataIn  in  1  serial data bit.
REQ-011 clrCnt  in  1  synchronous clear of matchCount.
REQ-012 begP  out  1  one-cycle pulse: pattern matched, frame begins.
REQ-013 endP  out  1  one-cycle pulse: frame complete.
REQ-014 inFrame  out  1  high while in FRAME state.
REQ-015 matchCount  out  CNT_W  saturating count of begP pulses.

Function
REQ-016 Window: PAT_W-bit shift register, new bit enters LSB on each sampled bit; fill counter tracks bits since last clear, saturating at PAT_W.
REQ-017 Match = fill==PAT_W and ((window XOR PATTERN) AND MASK)==0, evaluated on the updated window.
REQ-018 FSM states SEARCH and FRAME; reset state SEARCH.
REQ-019 SEARCH -> FRAME on the edge sampling a bit that completes a match; begP high for exactly the following cycle (latency 1 from last pattern bit).
REQ-020 In FRAME, frame counter increments per sampled bit; matches are ignored, no begP.
REQ-021 FRAME -> SEARCH on the edge sampling the FRAME_LEN-th bit after the match; endP high for exactly the following cycle.
REQ-022 On FRAME exit: RESYNC=0 clears window and fill; RESYNC=1 retains them, so a match completing on the very next sampled bit is legal.
REQ-023 Window keeps shifting during FRAME in both modes.
REQ-024 dataValid low: window, fill, frame counter and state hold; no pulses are generated.
REQ-025 begP and endP never high in the same cycle (FRAME_LEN>=1 guarantees it).
REQ-026 matchCount increments on each begP, saturating at 2^CNT_W-1; clrCnt wins over a simultaneous increment, result 0.
REQ-027 inFrame goes high together with begP and low together with endP.
REQ-028 All outputs registered; no combinational input-to-output path.

Reset
REQ-029 reset low at a rising edge: state SEARCH, window 0, fill 0, frame counter 0, matchCount 0, begP 0, endP 0, inFrame 0.
REQ-030 Reset mid-pattern or mid-frame discards all progress; a match afterwards requires PAT_W fresh sampled bits.
REQ-031 Reset has priority over dataValid and clrCnt.

Structure
REQ-032 Package detector_pkg holds the state enum (SEARCH, FRAME) and default parameter constants (PAT_W, PATTERN, FRAME_LEN, CNT_W).
REQ-033 Sub-module pattern_matcher holds window, fill counter and masked compare; outputs a registered-input match flag; top holds FSM, frame counter and statistics.

Verification
REQ-034 Defaults, reset then valid bits 1,1,1,0,1,1,0,0,0 -> begP one cycle after 9th bit, inFrame=1, matchCount=1.
REQ-035 After match, 16 valid bits containing 111011000 -> no begP; endP one cycle after 16th bit, inFrame=0.
REQ-036 Pattern with 3 dataValid-low cycles after bit 4 -> begP one cycle after the 9th valid bit, never earlier.
REQ-037 reset low at frame bit 7 -> all outputs 0 next cycle; next pattern needs all 9 bits; 8 bits 11011000 alone -> no begP.
REQ-038 CNT_W=2, 5 separated matches -> matchCount 1,2,3,3,3; clrCnt asserted on a begP cycle -> matchCount 0.
REQ-039 FRAME_LEN=1, RESYNC=1, frame bit completes pattern -> endP then begP on the next sampled bit; RESYNC=0 same stimulus -> no begP until 9 new bits.

Source files
------------

// File: rtl/detector_pkg.sv
// Shared types and default parameters for the serial sequence detector.
//   detState_t    : framing FSM states (SEARCH waits for a match, FRAME counts frame bits)
//   DEF_*         : default parameter values used by seq_detector_param
package detector_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    FRAME  = 1'b1
  } detState_t;

  localparam int          DEF_PAT_W     = 9;
  localparam logic [31:0] DEF_PATTERN   = 32'd472;   // 111011000, first bit is the MSB
  localparam int          DEF_FRAME_LEN = 16;
  localparam int          DEF_CNT_W     = 16;

endpackage

// File: rtl/pattern_matcher.sv
// Serial pattern window with masked compare.
//   clk, reset : clock and synchronous active-low reset
//   dataValid  : qualifies dataIn; window and fill hold while low
//   dataIn     : serial bit, shifted into the window LSB
//   clearWin   : on a sampled bit, empty the window instead of shifting
//   match      : the window as it will be after this sampled bit equals
//                PATTERN on all MASK positions and holds PAT_W real bits
module pattern_matcher #(
  parameter int             PAT_W   = 9,
  parameter logic [PAT_W-1:0] PATTERN = '0,
  parameter logic [PAT_W-1:0] MASK    = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic dataValid,
  input  logic dataIn,
  input  logic clearWin,
  output logic match
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  window, windowNext;
  logic [FILL_W-1:0] fill, fillNext;

  // Match looks at the updated window so the FSM can react on the very edge
  // that samples the last pattern bit; the result is registered by the top.
  always_comb begin
    windowNext = {window[PAT_W-2:0], dataIn};
    fillNext   = (fill == FULL) ? fill : fill + 1'b1;
    match      = dataValid && (fillNext == FULL) &&
                 (((windowNext ^ PATTERN) & MASK) == '0);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      window <= '0;
      fill   <= '0;
    end else if (dataValid) begin
      if (clearWin) begin
        window <= '0;
        fill   <= '0;
      end else begin
        window <= windowNext;
        fill   <= fillNext;
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial sequence detector with framing and match statistics.
//   clk, reset : clock and synchronous active-low reset (wins over all inputs)
//   dataValid  : dataIn is sampled only when high
//   dataIn     : serial data bit
//   clrCnt     : synchronous clear of matchCount
//   begP       : one-cycle pulse, pattern matched and a frame begins
//   endP       : one-cycle pulse, FRAME_LEN frame bits received
//   inFrame    : high while a frame is in progress
//   matchCount : saturating count of begP pulses
module seq_detector_param
  import detector_pkg::*;
#(
  parameter int               PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN   = PAT_W'(DEF_PATTERN),
  parameter logic [PAT_W-1:0] MASK      = '1,
  parameter int               FRAME_LEN = DEF_FRAME_LEN,
  parameter bit               RESYNC    = 1'b0,
  parameter int               CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dataValid,
  input  logic             dataIn,
  input  logic             clrCnt,
  output logic             begP,
  output logic             endP,
  output logic             inFrame,
  output logic [CNT_W-1:0] matchCount
);

  localparam int FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCNT_W-1:0] LAST_IDX = FCNT_W'(FRAME_LEN - 1);

  detState_t         state, stateNext;
  logic [FCNT_W-1:0] frameCnt, frameCntNext;
  logic              match, clearWin, begPNext, endPNext;

  pattern_matcher #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .MASK    (MASK)
  ) uMatcher (
    .clk       (clk),
    .reset     (reset),
    .dataValid (dataValid),
    .dataIn    (dataIn),
    .clearWin  (clearWin),
    .match     (match)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    stateNext    = state;
    frameCntNext = frameCnt;
    begPNext     = 1'b0;
    endPNext     = 1'b0;
    clearWin     = 1'b0;
    unique case (state)
      SEARCH: begin
        if (match) begin
          stateNext    = FRAME;
          begPNext     = 1'b1;
          frameCntNext = '0;
        end
      end
      FRAME: begin
        // Matches are ignored here; the window still shifts inside the matcher.
        if (dataValid) begin
          if (frameCnt == LAST_IDX) begin
            stateNext    = SEARCH;
            endPNext     = 1'b1;
            frameCntNext = '0;
            clearWin     = ~RESYNC;
          end else begin
            frameCntNext = frameCnt + 1'b1;
          end
        end
      end
      default: stateNext = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= SEARCH;
      frameCnt   <= '0;
      begP       <= 1'b0;
      endP       <= 1'b0;
      matchCount <= '0;
    end else begin
      state    <= stateNext;
      frameCnt <= frameCntNext;
      begP     <= begPNext;
      endP     <= endPNext;
      // Counts registered begP pulses, so a clear during a begP cycle
      // collides with that pulse's increment and the clear wins.
      if (clrCnt) begin
        matchCount <= '0;
      end else if (begP && (matchCount != '1)) begin
        matchCount <= matchCount + 1'b1;
      end
    end
  end

  assign inFrame = (state == FRAME);

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset, dataValid, dataIn, clrCnt;

  // Default instance
  logic        begP, endP, inFrame;
  logic [15:0] matchCount;
  // Narrow counter instance
  logic        begPC, endPC, inFrameC;
  logic [1:0]  matchCountC;
  // FRAME_LEN=1, alternating pattern, RESYNC=1 and RESYNC=0
  logic        begP1, endP1, inFrame1;
  logic [15:0] matchCount1;
  logic        begP0, endP0, inFrame0;
  logic [15:0] matchCount0;

  int checks = 0;
  int fails  = 0;

  logic [8:0]  pat   = 9'b111011000;
  logic [8:0]  alt   = 9'b101010101;
  logic [15:0] fbits = 16'b1110110000000000;
  logic [7:0]  tail8 = 8'b11011000;
  logic [6:0]  r0bits = 7'b0101010;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .dataValid(dataValid), .dataIn(dataIn), .clrCnt(clrCnt),
    .begP(begP), .endP(endP), .inFrame(inFrame), .matchCount(matchCount)
  );

  seq_detector_param #(.CNT_W(2)) dutC (
    .clk(clk), .reset(reset), .dataValid(dataValid), .dataIn(dataIn), .clrCnt(clrCnt),
    .begP(begPC), .endP(endPC), .inFrame(inFrameC), .matchCount(matchCountC)
  );

  seq_detector_param #(.PATTERN(9'b101010101), .FRAME_LEN(1), .RESYNC(1'b1)) dutR1 (
    .clk(clk), .reset(reset), .dataValid(dataValid), .dataIn(dataIn), .clrCnt(clrCnt),
    .begP(begP1), .endP(endP1), .inFrame(inFrame1), .matchCount(matchCount1)
  );

  seq_detector_param #(.PATTERN(9'b101010101), .FRAME_LEN(1), .RESYNC(1'b0)) dutR0 (
    .clk(clk), .reset(reset), .dataValid(dataValid), .dataIn(dataIn), .clrCnt(clrCnt),
    .begP(begP0), .endP(endP0), .inFrame(inFrame0), .matchCount(matchCount0)
  );

  task automatic stepBit(input logic b);
    dataValid = 1'b1;
    dataIn    = b;
    @(posedge clk);
    #1;
    dataValid = 1'b0;
  endtask

  task automatic idle();
    dataValid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset     = 1'b0;
    dataValid = 1'b0;
    dataIn    = 1'b0;
    clrCnt    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({begP, endP, inFrame} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b expected 000", {begP, endP, inFrame});
    end
    checks++;
    if (matchCount !== 16'd0) begin
      fails++; $display("FAIL reset_count: got %0d expected 0", matchCount);
    end
  endtask

  task automatic test_match();
    doReset();
    for (int i = 8; i >= 1; i--) begin
      stepBit(pat[i]);
      checks++;
      if (begP !== 1'b0) begin
        fails++; $display("FAIL match_early bit%0d: got begP=%b expected 0", 9 - i, begP);
      end
    end
    stepBit(pat[0]);
    checks++;
    if ({begP, inFrame, endP} !== 3'b110) begin
      fails++; $display("FAIL match_begP: got begP,inFrame,endP=%b expected 110", {begP, inFrame, endP});
    end
    idle();
    checks++;
    if ({begP, inFrame} !== 2'b01) begin
      fails++; $display("FAIL match_pulse_len: got begP,inFrame=%b expected 01", {begP, inFrame});
    end
    checks++;
    if (matchCount !== 16'd1) begin
      fails++; $display("FAIL match_count: got %0d expected 1", matchCount);
    end
  endtask

  task automatic test_frame();
    for (int i = 15; i >= 1; i--) begin
      stepBit(fbits[i]);
      checks++;
      if ({begP, endP, inFrame} !== 3'b001) begin
        fails++; $display("FAIL frame_body bit%0d: got begP,endP,inFrame=%b expected 001", 16 - i, {begP, endP, inFrame});
      end
    end
    stepBit(fbits[0]);
    checks++;
    if ({begP, endP, inFrame} !== 3'b010) begin
      fails++; $display("FAIL frame_end: got begP,endP,inFrame=%b expected 010", {begP, endP, inFrame});
    end
    idle();
    checks++;
    if ({endP, inFrame} !== 2'b00) begin
      fails++; $display("FAIL frame_end_pulse: got endP,inFrame=%b expected 00", {endP, inFrame});
    end
  endtask

  task automatic test_gap();
    doReset();
    for (int i = 8; i >= 5; i--) stepBit(pat[i]);
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if (begP !== 1'b0) begin
        fails++; $display("FAIL gap_idle%0d: got begP=%b expected 0", k, begP);
      end
    end
    for (int i = 4; i >= 1; i--) begin
      stepBit(pat[i]);
      checks++;
      if (begP !== 1'b0) begin
        fails++; $display("FAIL gap_early bit%0d: got begP=%b expected 0", 9 - i, begP);
      end
    end
    stepBit(pat[0]);
    checks++;
    if (begP !== 1'b1) begin
      fails++; $display("FAIL gap_match: got begP=%b expected 1", begP);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 8; i >= 0; i--) stepBit(pat[i]);
    for (int k = 0; k < 6; k++) stepBit(1'b0);
    stepBit(1'b1);
    checks++;
    if (inFrame !== 1'b1) begin
      fails++; $display("FAIL midrst_inframe: got %b expected 1", inFrame);
    end
    // Reset together with a valid bit and a clear; reset must win.
    reset = 1'b0; dataValid = 1'b1; dataIn = 1'b1; clrCnt = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1; dataValid = 1'b0; clrCnt = 1'b0;
    checks++;
    if ({begP, endP, inFrame} !== 3'b000 || matchCount !== 16'd0) begin
      fails++; $display("FAIL midrst_outputs: got flags=%b count=%0d expected 000 and 0", {begP, endP, inFrame}, matchCount);
    end
    for (int i = 7; i >= 0; i--) begin
      stepBit(tail8[i]);
      checks++;
      if (begP !== 1'b0) begin
        fails++; $display("FAIL midrst_stale bit%0d: got begP=%b expected 0", 8 - i, begP);
      end
    end
    doReset();
    for (int i = 8; i >= 0; i--) stepBit(pat[i]);
    checks++;
    if (begP !== 1'b1) begin
      fails++; $display("FAIL midrst_rematch: got begP=%b expected 1", begP);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] expCnt;
    doReset();
    for (int i = 8; i >= 0; i--) stepBit(pat[i]);
    checks++;
    if (begPC !== 1'b1) begin
      fails++; $display("FAIL sat_first_begP: got %b expected 1", begPC);
    end
    clrCnt = 1'b1;
    idle();
    clrCnt = 1'b0;
    checks++;
    if (matchCountC !== 2'd0) begin
      fails++; $display("FAIL sat_clear_wins: got %0d expected 0", matchCountC);
    end
    for (int k = 0; k < 16; k++) stepBit(1'b0);
    idle();
    for (int m = 1; m <= 5; m++) begin
      for (int i = 8; i >= 0; i--) stepBit(pat[i]);
      for (int k = 0; k < 16; k++) stepBit(1'b0);
      idle();
      expCnt = (m > 3) ? 2'd3 : 2'(m);
      checks++;
      if (matchCountC !== expCnt) begin
        fails++; $display("FAIL sat_count match%0d: got %0d expected %0d", m, matchCountC, expCnt);
      end
    end
  endtask

  task automatic test_resync();
    doReset();
    for (int i = 8; i >= 0; i--) stepBit(alt[i]);
    checks++;
    if ({begP1, begP0} !== 2'b11) begin
      fails++; $display("FAIL resync_first: got begP1,begP0=%b expected 11", {begP1, begP0});
    end
    stepBit(1'b0);
    checks++;
    if ({endP1, endP0, begP1} !== 3'b110) begin
      fails++; $display("FAIL resync_end: got endP1,endP0,begP1=%b expected 110", {endP1, endP0, begP1});
    end
    stepBit(1'b1);
    checks++;
    if ({begP1, endP1, inFrame1} !== 3'b101) begin
      fails++; $display("FAIL resync1_rematch: got begP1,endP1,inFrame1=%b expected 101", {begP1, endP1, inFrame1});
    end
    checks++;
    if (begP0 !== 1'b0) begin
      fails++; $display("FAIL resync0_no_rematch: got begP0=%b expected 0", begP0);
    end
    for (int i = 6; i >= 0; i--) begin
      stepBit(r0bits[i]);
      checks++;
      if (begP0 !== 1'b0) begin
        fails++; $display("FAIL resync0_early new%0d: got begP0=%b expected 0", 8 - i, begP0);
      end
    end
    stepBit(1'b1);
    checks++;
    if (begP0 !== 1'b1) begin
      fails++; $display("FAIL resync0_ninth: got begP0=%b expected 1", begP0);
    end
  endtask

  initial begin
    reset = 1'b1; dataValid = 1'b0; dataIn = 1'b0; clrCnt = 1'b0;
    test_reset();
    test_match();
    test_frame();
    test_gap();
    test_reset_mid();
    test_saturate();
    test_resync();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
